// File: rtl/s1_pkg.sv
// ============================================================================
// Module   : s1_pkg
// Brief    : Shared sizes, state encoding and the 18x8 transpose helper for
//            the RB1 transpose transmitter. S1_PARITY_EN adds a parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package s1_pkg;

    localparam int N_BYTES     = 18;
    localparam int N_WORDS     = 8;
    localparam int IDX_W       = 3;
    localparam int DATA_W      = 18;
    localparam int ADDR_W      = 5;
    localparam int CNT_W       = 5;
    localparam int PAYLOAD_LEN = IDX_W + DATA_W;
`ifdef S1_PARITY_EN
    localparam int FRAME_LEN   = PAYLOAD_LEN + 1;
`else
    localparam int FRAME_LEN   = PAYLOAD_LEN;
`endif

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Word n gathers bit (7-n) of every byte, byte 0 landing in the MSB.
    function automatic logic [DATA_W-1:0] transpose_word(
        input logic [N_BYTES*8-1:0] bytes,
        input logic [IDX_W-1:0]     n
    );
        logic [DATA_W-1:0] w;
        logic [7:0]        b;
        w = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            b = bytes[i*8 +: 8];
            w[DATA_W-1-i] = b[3'd7 - n];
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/s1_transpose_tx_frame_serializer.sv
// ============================================================================
// Module   : frame_serializer
// Brief    : Parallel-load MSB-first shifter producing the active-low sen
//            frame and sd data; S1_PARITY_EN appends an XOR parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_serializer
    import s1_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [PAYLOAD_LEN-1:0] i_payload,
    output logic                   o_sen,
    output logic                   o_sd,
    output logic                   o_last
);

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(FRAME_LEN - 1);

    logic [FRAME_LEN-1:0] w_frame;
    logic [FRAME_LEN-1:0] r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_sen;
    logic                 r_sd;

`ifdef S1_PARITY_EN
    assign w_frame = {i_payload, ^i_payload};
`else
    assign w_frame = i_payload;
`endif

    // r_shift holds the bits still to be sent; the current bit already sits in r_sd.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_sen   <= 1'b1;
            r_sd    <= 1'b0;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_load) begin
            r_busy  <= 1'b1;
            r_sen   <= 1'b0;
            r_sd    <= w_frame[FRAME_LEN-1];
            r_shift <= {w_frame[FRAME_LEN-2:0], 1'b0};
            r_cnt   <= '0;
        end else if (r_busy) begin
            if (r_cnt == c_last_bit) begin
                r_busy <= 1'b0;
                r_sen  <= 1'b1;
                r_sd   <= 1'b0;
            end else begin
                r_sd    <= r_shift[FRAME_LEN-1];
                r_shift <= {r_shift[FRAME_LEN-2:0], 1'b0};
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    assign o_sen  = r_sen;
    assign o_sd   = r_sd;
    assign o_last = r_busy && (r_cnt == c_last_bit);

endmodule

`default_nettype wire

// File: rtl/s1_transpose_tx.sv
// ============================================================================
// Module   : s1_transpose_tx
// Brief    : Reads 18 bytes from RB1, transposes them into eight 18-bit words
//            and sends each as a serial frame. S1_PARITY_EN adds frame parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module s1_transpose_tx
    import s1_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              RB1_RW,
    output logic [ADDR_W-1:0] RB1_A,
    output logic [7:0]        RB1_D,
    input  logic [7:0]        RB1_Q,
    output logic              sen,
    output logic              sd
);

    localparam logic [CNT_W-1:0] c_n_bytes  = CNT_W'(N_BYTES);
    localparam logic [CNT_W-1:0] c_load_end = CNT_W'(N_BYTES + 1);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_WORDS - 1);

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [IDX_W-1:0]         r_idx;
    logic [ADDR_W-1:0]        r_addr;
    logic [7:0]               r_buf [N_BYTES];
    logic [N_BYTES*8-1:0]     w_bytes;
    logic [PAYLOAD_LEN-1:0]   w_payload;
    logic                     w_load;
    logic                     w_last;

    // The last byte arrives on the same edge frame 0 is loaded, so bypass it.
    always_comb begin
        w_bytes = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            w_bytes[i*8 +: 8] = r_buf[i];
        end
        if (r_state == ST_LOAD) begin
            w_bytes[(N_BYTES-1)*8 +: 8] = RB1_Q;
        end
    end

    assign w_payload = {r_idx, transpose_word(w_bytes, r_idx)};
    assign w_load    = ((r_state == ST_LOAD) && (r_cnt == c_load_end)) || (r_state == ST_GAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_addr <= (r_cnt < c_n_bytes) ? r_cnt : '0;
                    if (r_cnt == c_load_end) begin
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_last) begin
                        if (r_idx == c_last_idx) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP:  r_state <= ST_SEND;
                ST_DONE: r_state <= ST_DONE;
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // Data for the address shown in cycle k is captured two edges later.
    always_ff @(posedge clk) begin
        if ((r_state == ST_LOAD) && (r_cnt >= 5'd2) && (r_cnt <= c_load_end)) begin
            r_buf[r_cnt - 5'd2] <= RB1_Q;
        end
    end

    frame_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_payload (w_payload),
        .o_sen     (sen),
        .o_sd      (sd),
        .o_last    (w_last)
    );

    assign RB1_RW = 1'b1;
    assign RB1_D  = 8'h00;
    assign RB1_A  = r_addr;

endmodule

`default_nettype wire
